// File: rtl/solver_ctrl_pio_if.sv
// rtl/solver_ctrl_pio_if.sv - Avalon-MM register bus bundle for the solver control PIO
interface solver_ctrl_pio_if;
   logic [2:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata;

   modport master (output address, chipselect, write_n, writedata, input readdata);
   modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/solver_ctrl_pio.sv
// rtl/solver_ctrl_pio.sv - solver control output PIO (level, set/clear, pulse); pulse engine under SOLVER_CTRL_PIO_PULSE_EN
module solver_ctrl_pio #(
   parameter int unsigned      WIDTH        = 8,
   parameter int unsigned      PULSE_CYCLES = 4,
   parameter logic [WIDTH-1:0] RESET_VALUE  = '0
) (
   input  logic             clk,
   input  logic             reset_n,
   solver_ctrl_pio_if.slave bus,
   output logic [WIDTH-1:0] out_port
);

   localparam logic [2:0] ADDR_DATA     = 3'd0;
   localparam logic [2:0] ADDR_OUTSET   = 3'd4;
   localparam logic [2:0] ADDR_OUTCLEAR = 3'd5;

   logic             wr_en;
   logic             rd_en;
   logic [WIDTH-1:0] wr_bits;
   logic [WIDTH-1:0] data_d, data_q;
   logic [WIDTH-1:0] pmask_q;
   logic [31:0]      readdata_d, readdata_q;
   logic             unused_wr_hi;

   assign wr_en        = bus.chipselect & ~bus.write_n;
   assign rd_en        = bus.chipselect &  bus.write_n;
   assign wr_bits      = bus.writedata[WIDTH-1:0];
   assign unused_wr_hi = ^bus.writedata[31:WIDTH];

   // Level register: full replace, atomic set and atomic clear
   always_comb begin
      data_d = data_q;
      if (wr_en) begin
         case (bus.address)
            ADDR_DATA:     data_d = wr_bits;
            ADDR_OUTSET:   data_d = data_q | wr_bits;
            ADDR_OUTCLEAR: data_d = data_q & ~wr_bits;
            default:       data_d = data_q;
         endcase
      end
   end

   // Level register storage
   always_ff @(posedge clk) begin
      if (!reset_n) data_q <= RESET_VALUE;
      else          data_q <= data_d;
   end

`ifdef SOLVER_CTRL_PIO_PULSE_EN
   localparam logic [2:0]  ADDR_STATUS = 3'd1;
   localparam logic [2:0]  ADDR_PULSE  = 3'd2;
   localparam int unsigned CW          = $clog2(PULSE_CYCLES + 1);
   localparam logic [CW-1:0] CNT_RELOAD = CW'(PULSE_CYCLES);
   localparam logic [CW-1:0] CNT_ONE    = CW'(1);

   typedef enum logic {ST_IDLE, ST_ACTIVE} pulse_state_e;

   pulse_state_e     state_d, state_q;
   logic [CW-1:0]    cnt_d, cnt_q;
   logic [WIDTH-1:0] pmask_d;
   logic             pulse_wr;
   logic [31:0]      status_word;

   // An all-zero PULSE write must not restart the counter
   assign pulse_wr = wr_en && (bus.address == ADDR_PULSE) && (wr_bits != '0);

   // Shared pulse counter: new bits join the pending set and all extend together,
   // except on the expiring cycle where the old set is dropped
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      pmask_d = pmask_q;
      case (state_q)
         ST_IDLE: begin
            if (pulse_wr) begin
               pmask_d = wr_bits;
               cnt_d   = CNT_RELOAD;
               state_d = ST_ACTIVE;
            end
         end
         ST_ACTIVE: begin
            if (pulse_wr) begin
               pmask_d = (cnt_q == CNT_ONE) ? wr_bits : (pmask_q | wr_bits);
               cnt_d   = CNT_RELOAD;
            end else if (cnt_q == CNT_ONE) begin
               pmask_d = '0;
               cnt_d   = '0;
               state_d = ST_IDLE;
            end else begin
               cnt_d   = cnt_q - CNT_ONE;
            end
         end
      endcase
   end

   // Pulse engine registers; reset aborts any pending pulse
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         pmask_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         pmask_q <= pmask_d;
      end
   end

   // STATUS word: pending pulse bits plus BUSY in the top bit
   always_comb begin
      status_word            = '0;
      status_word[WIDTH-1:0] = pmask_q;
      status_word[31]        = (cnt_q != '0);
   end
`else
   assign pmask_q = '0;
`endif

   // Read mux, loaded every cycle; zero unless a read is in progress
   always_comb begin
      readdata_d = '0;
      if (rd_en) begin
         case (bus.address)
            ADDR_DATA:   readdata_d[WIDTH-1:0] = data_q;
`ifdef SOLVER_CTRL_PIO_PULSE_EN
            ADDR_STATUS: readdata_d = status_word;
`endif
            default:     readdata_d = '0;
         endcase
      end
   end

   // Registered read data
   always_ff @(posedge clk) begin
      if (!reset_n) readdata_q <= '0;
      else          readdata_q <= readdata_d;
   end

   assign bus.readdata = readdata_q;
   assign out_port     = data_q | pmask_q;

endmodule
